// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RISC-V load/store funct3 encodings, the LSU FSM state type and
// a helper that tells whether a funct3 value is legal for a load or a store.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Unsigned variants only exist for loads; every other encoding is illegal.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane steering for the load/store unit (purely combinational).
// Ports:
//   word       in  32  word read from memory
//   addr_lo    in  2   byte offset within the word
//   funct3     in  3   access size / signedness
//   wdata      in  32  store data, low-aligned
//   load_data  out 32  selected lane, sign- or zero-extended
//   store_word out 32  word with the addressed lane replaced by store data
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        byte_s    = 8'd0;
        half_s    = 16'd0;
        load_data = 32'd0;
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'd0;
        endcase
        half_s = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'd0, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'd0, half_s};
            F3_W:    load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Read-modify-write merge: the memory port always writes four bytes.
    always_comb begin
        store_word = wdata;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    store_word = {word[31:8], wdata[7:0]};
                    2'd1:    store_word = {word[31:16], wdata[7:0], word[7:0]};
                    2'd2:    store_word = {word[31:24], wdata[7:0], word[15:0]};
                    2'd3:    store_word = {wdata[7:0], word[23:0]};
                    default: store_word = word;
                endcase
            end
            F3_H:    store_word = addr_lo[1] ? {wdata[15:0], word[15:0]}
                                             : {word[31:16], wdata[15:0]};
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from execute, drives the data
// memory word port and returns extended load data or a fault.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (accept on valid && ready)
//   req_store, req_funct3,
//   req_addr, req_wdata           request fields
//   resp_valid, resp_rdata,
//   resp_fault                    one-cycle completion pulse and result
//   mem_addr, mem_write_data,
//   mem_write, mem_read           memory word port (commit on mem_write edge)
//   mem_data_out                  combinational read data for mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_data_out
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    lsu_state_t  state_r, state_next_s;
    logic        accept_s, fault_s;
    logic [31:0] aligned_s;
    logic [32:0] end_addr_s;
    logic        misalign_s;
    logic [1:0]  addr_lo_r;
    logic [2:0]  funct3_r;
    logic        store_r;
    logic [31:0] wdata_r;
    logic [31:0] lane_load_s, lane_store_s;
    logic        resp_valid_r, resp_fault_r;
    logic [31:0] resp_rdata_r, mem_addr_r, mem_write_data_r;

    assign req_ready      = (state_r == IDLE) && rst_n;
    assign accept_s       = req_valid && req_ready;
    assign mem_read       = (state_r == RD) && rst_n;
    assign mem_write      = (state_r == WR) && rst_n;
    assign resp_valid     = resp_valid_r;
    assign resp_fault     = resp_fault_r;
    assign resp_rdata     = resp_rdata_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_write_data_r;

    // Fault check on the incoming request; end address computed in 33 bits so
    // addresses near 2^32 cannot wrap back into range.
    always_comb begin
        aligned_s  = {req_addr[31:2], 2'b00};
        end_addr_s = {1'b0, aligned_s} + 33'd3;
        case (req_funct3)
            F3_H, F3_HU: misalign_s = req_addr[0];
            F3_W:        misalign_s = (req_addr[1:0] != 2'b00);
            default:     misalign_s = 1'b0;
        endcase
        fault_s = misalign_s || !f3_legal(req_store, req_funct3) || (end_addr_s >= MEM_LIMIT);
    end

    lsu_lane u_lane (
        .word       (mem_data_out),
        .addr_lo    (addr_lo_r),
        .funct3     (funct3_r),
        .wdata      (wdata_r),
        .load_data  (lane_load_s),
        .store_word (lane_store_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; only SB/SH stores pass through RD on their way to WR.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (fault_s) begin
                    state_next_s = RESP;
                end else if (!req_store) begin
                    state_next_s = RD;
                end else if (req_funct3 == F3_W) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            RD:      state_next_s = store_r ? WR : RESP;
            WR:      state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request latches, registered memory address/write data and response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_lo_r        <= 2'd0;
            funct3_r         <= 3'd0;
            store_r          <= 1'b0;
            wdata_r          <= 32'd0;
            resp_valid_r     <= 1'b0;
            resp_fault_r     <= 1'b0;
            resp_rdata_r     <= 32'd0;
            mem_addr_r       <= 32'd0;
            mem_write_data_r <= 32'd0;
        end else begin
            resp_valid_r <= (state_next_s == RESP);
            if (accept_s) begin
                addr_lo_r        <= req_addr[1:0];
                funct3_r         <= req_funct3;
                store_r          <= req_store;
                wdata_r          <= req_wdata;
                mem_addr_r       <= aligned_s;
                // SW writes this verbatim; SB/SH replace it with the merge in RD.
                mem_write_data_r <= req_wdata;
                resp_rdata_r     <= 32'd0;
                resp_fault_r     <= fault_s;
            end else if (state_r == RD) begin
                if (store_r) begin
                    mem_write_data_r <= lane_store_s;
                end else begin
                    resp_rdata_r <= lane_load_s;
                end
            end else if (state_r == RESP) begin
                resp_fault_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory
// and an in-order response scoreboard.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:255];
    logic [32:0] sb_q [$];
    logic [32:0] sb_e;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_data_out   (mem_data_out)
    );

    assign mem_data_out = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected store word: mask of the access size shifted into its lane.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(addr[1:0]);
        mask = (f3 == 3'b000) ? 32'h0000_00FF : (f3 == 3'b001) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mask = mask << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Response monitor: every pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, sb_e[31:0]);
                check("resp_fault", 32'(resp_fault), 32'(sb_e[32]));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f);
        int lat, rd_c, wr_c;
        logic [31:0] exp_wd;
        if (exp_f) begin
            lat = 1; rd_c = 0; wr_c = 0;
        end else if (!st) begin
            lat = 2; rd_c = 1; wr_c = 0;
        end else if (f3 == 3'b010) begin
            lat = 2; rd_c = 0; wr_c = 1;
        end else begin
            lat = 3; rd_c = 1; wr_c = 2;
        end
        wait_ready();
        exp_wd = ref_merge(mem[addr[9:2]], addr, f3, wd);
        req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        sb_q.push_back({exp_f, (st || exp_f) ? 32'd0 : exp_rd});
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            check("mem_read", 32'(mem_read), 32'(c == rd_c));
            check("mem_write", 32'(mem_write), 32'(c == wr_c));
            check("resp_valid", 32'(resp_valid), 32'(c == lat));
            check("ready_busy", 32'(req_ready), 32'd0);
            if (c == rd_c || c == wr_c) check("mem_addr", mem_addr, addr & ~32'd3);
            if (c == wr_c) check("mem_write_data", mem_write_data, exp_wd);
            @(posedge clk); #1;
        end
        check("ready_after", 32'(req_ready), 32'd1);
        if (st && !exp_f) check("mem_word", mem[addr[9:2]], exp_wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'h8765_43A1;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Loads with sign/zero extension.
        run_op(1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFF_FFA1, 1'b0);
        run_op(1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_8765, 1'b0);
        run_op(1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_8765, 1'b0);
        run_op(1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_0087, 1'b0);

        // Sub-word store via read-modify-write, then read back.
        run_op(1'b1, 3'b000, 32'h11, 32'h0000_005C, 32'd0, 1'b0);
        check("sb_const", mem[4], 32'h8765_5CA1);
        run_op(1'b0, 3'b010, 32'h10, 32'd0, 32'h8765_5CA1, 1'b0);

        // Faults: misaligned, illegal funct3, out of range; then last legal word.
        run_op(1'b0, 3'b010, 32'h13, 32'd0, 32'd0, 1'b1);
        run_op(1'b1, 3'b001, 32'h11, 32'hFFFF, 32'd0, 1'b1);
        run_op(1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
        run_op(1'b1, 3'b100, 32'h10, 32'h55, 32'd0, 1'b1);
        run_op(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, 32'd0, 1'b1);
        run_op(1'b1, 3'b010, 32'h3FC, 32'h1234_5678, 32'd0, 1'b0);
        run_op(1'b0, 3'b010, 32'h3FC, 32'd0, 32'h1234_5678, 1'b0);
        check("mem_unchanged_after_faults", mem[4], 32'h8765_5CA1);

        // Reset during the write cycle of SH abandons the request.
        wait_ready();
        req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h0000_BEEF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_sh_c1_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        check("rst_sh_c2_write_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sh_write_forced", 32'(mem_write), 32'd0);
        check("rst_sh_ready_forced", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_sh_ready_return", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_sh_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("rst_sh_mem_kept", mem[4], 32'h8765_5CA1);

        // Back-to-back loads with req_valid held; busy cycles carry a junk request.
        wait_ready();
        for (int k = 0; k <= 6; k++) begin
            if (k % 3 == 0) begin
                check("b2b_ready_idle", 32'(req_ready), 32'd1);
                req_store = 1'b0;
                case (k / 3)
                    0: begin req_funct3 = 3'b010; req_addr = 32'h10;  sb_q.push_back({1'b0, 32'h8765_5CA1}); end
                    1: begin req_funct3 = 3'b100; req_addr = 32'h12;  sb_q.push_back({1'b0, 32'h0000_0065}); end
                    default: begin req_funct3 = 3'b001; req_addr = 32'h3FC; sb_q.push_back({1'b0, 32'h0000_5678}); end
                endcase
            end else begin
                check("b2b_ready_busy", 32'(req_ready), 32'd0);
                req_store = 1'b0; req_funct3 = 3'b011; req_addr = 32'h3FC;
            end
            req_valid = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator of the RISC-V core's data path. Takes one load or store per request from the execute stage, drives the byte-addressed data memory's word port (address, write data, write/read strobes, combinational read data), and returns sign/zero-extended load data or a fault. Sub-word stores use read-modify-write, because the memory port always writes all four bytes.

## Interface
- MEM_BYTES, 1024: data memory size in bytes; any access with aligned address + 3 ≥ MEM_BYTES faults.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on an edge with req_valid && req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, low-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid: misaligned, out of range, or illegal funct3.
- mem_addr  out  32  word-aligned address, req_addr & ~3.
- mem_write_data  out  32  full word to write.
- mem_write  out  1  write strobe; the memory commits on that edge.
- mem_read  out  1  read strobe.
- mem_data_out  in  32  combinational read data for mem_addr.

## Operation
- FSM states: IDLE, RD, WR, RESP. req_ready = (state == IDLE) && rst_n.
- On accept, latch addr, funct3, store, wdata, and the fault check.
- Fault if any of these holds: H with addr[0] ≠ 0; W with addr[1:0] ≠ 0; funct3 ∉ {000,001,010,100,101} for loads; funct3 ∉ {000,001,010} for stores; out of range.
- Accept transitions:
  - Fault: IDLE→RESP. No memory strobe.
  - Load: IDLE→RD→RESP.
  - SW: IDLE→WR→RESP.
  - SB/SH: IDLE→RD→WR→RESP.
  - RESP→IDLE always.
- RD: mem_read = 1. At the edge, register mem_data_out.
  - Loads: extract lane (byte lane addr[1:0]; half lane addr[1]). B/H sign-extend; BU/HU zero-extend.
  - SB/SH: keep the raw word for merge.
- WR: mem_write = 1.
  - SW: mem_write_data = wdata.
  - SB: registered word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: registered word with half lane addr[1] replaced by wdata[15:0].
- mem_addr holds the latched aligned address outside RD/WR. mem_read/mem_write are 0 outside RD/WR.
- req_valid while busy is ignored, not queued.

## Timing
- Accept edge E0. Cycle n is the cycle after edge En.
- Load: mem_read in cycle 1; resp_valid in cycle 2.
- SW: mem_write in cycle 1; resp_valid in cycle 2.
- SB/SH: mem_read in cycle 1, mem_write in cycle 2; resp_valid in cycle 3.
- Fault: resp_valid + resp_fault in cycle 1.
- Back-to-back: req_ready returns in the cycle after RESP, so the minimum request spacing is 3 cycles (4 for SB/SH).
- Reset values: state IDLE; resp_valid, resp_fault, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_write_data = 0.
- While rst_n is low: mem_write, mem_read, and req_ready are forced 0 combinationally.
- Reset mid-operation abandons the request: no write, no response; memory is unchanged if the reset is applied in or before WR.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, RD, WR, RESP}.
- Sub-module lsu_lane (combinational): takes word, addr[1:0], funct3 and wdata; returns extracted/extended load data and the merged store word.
- Top level: FSM, latches, fault check.

## Test plan
Preload memory word 0x10 = 0x876543A1.

- LB 0x10 → mem_read only in cycle 1 with mem_addr 0x10; resp_rdata 0xFFFFFFA1 in cycle 2, fault 0.
- LHU 0x12 → 0x00008765; LH 0x12 → 0xFFFF8765; LBU 0x13 → 0x00000087.
- SB 0x5C to 0x11:
  - cycle 1: mem_read.
  - cycle 2: mem_write, mem_addr 0x10, mem_write_data 0x87655CA1.
  - cycle 3: resp_valid.
  - A following LW 0x10 returns 0x87655CA1.
- Faults, each with no strobes and a fault response in cycle 1:
  - LW 0x13.
  - SH 0x11.
  - Load funct3 011.
  - SW 0x400 (MEM_BYTES = 1024).
  - Contrast: SW 0x3FC succeeds.
- rst_n low in cycle 2 of SH 0xBEEF to 0x12 → mem_write 0, no resp_valid, word 0x10 unchanged; req_ready 1 in the first cycle after rst_n returns high.
- req_valid held high with 3 loads queued → accepts exactly on IDLE cycles (spacing 3); requests presented while busy are not accepted; responses in order with correct data.
